// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM arbiter: port ids, SRAM op
// encodings, and the request/tag records carried through the pipeline.
package sram_pkg;

    localparam int ADDRESS_WIDTH = 15;
    localparam int DATA_WIDTH    = 32;

    // Requester identity; port 0 is instruction fetch, port 1 is load/store.
    typedef logic port_id_t;

    localparam port_id_t PORT_FETCH = 1'b0;
    localparam port_id_t PORT_LSU   = 1'b1;

    // SRAM readWrite pin encoding.
    localparam logic SRAM_READ  = 1'b1;
    localparam logic SRAM_WRITE = 1'b0;

    // One request as presented by a requester.
    typedef struct packed {
        logic                     write;
        logic [ADDRESS_WIDTH-1:0] address;
        logic [DATA_WIDTH-1:0]    data;
    } sram_req_t;

    // Identity of an in-flight access, used to steer its response.
    typedef struct packed {
        port_id_t port;
        logic     write;
    } sram_tag_t;

    // Map a requester's write flag onto the SRAM readWrite pin.
    function automatic logic sram_op(input logic write);
        logic op;
        if (write) begin
            op = SRAM_WRITE;
        end else begin
            op = SRAM_READ;
        end
        return op;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way arbiter: combinational grant with a registered preference pointer.
// In round-robin mode the pointer moves to the port that was not just served;
// in fixed mode port 0 is always preferred.
module rr_arbiter2 #(
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic valid0,
    input  logic valid1,
    output logic ready0,
    output logic ready1,
    output logic accept,
    output logic grant_port
);

    import sram_pkg::*;

    port_id_t preferred_r;
    port_id_t pick_s;

    // Choose the winner: a lone requester wins, a tie goes to the preferred port.
    always_comb begin
        pick_s = PORT_FETCH;
        if (valid0 && valid1) begin
            pick_s = preferred_r;
        end else if (valid1) begin
            pick_s = PORT_LSU;
        end else begin
            pick_s = PORT_FETCH;
        end
    end

    // Qualify the pick with its valid; no grant is ever given during reset.
    always_comb begin
        ready0 = 1'b0;
        ready1 = 1'b0;
        if (reset) begin
            ready0 = 1'b0;
            ready1 = 1'b0;
        end else begin
            ready0 = valid0 && (pick_s == PORT_FETCH);
            ready1 = valid1 && (pick_s == PORT_LSU);
        end
    end

    assign accept     = ready0 | ready1;
    assign grant_port = pick_s;

    // Move preference away from the port just served (pinned to port 0 in fixed mode).
    always_ff @(posedge clock) begin
        if (reset) begin
            preferred_r <= PORT_FETCH;
        end else if (FIXED_PRIORITY) begin
            preferred_r <= PORT_FETCH;
        end else if (accept) begin
            preferred_r <= ~pick_s;
        end else begin
            preferred_r <= preferred_r;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Arbiter and sequencer in front of the single-port synchronous SRAM.
// Edge N (acceptance) loads the SRAM command registers, the SRAM executes at
// edge N+1 while the response stage captures the tag, and the response is
// presented during cycle N+2 on the originating port. Read data comes straight
// from the SRAM output register, which is valid in exactly that cycle.
module sram_arbiter #(
    parameter int ADDRESS_WIDTH  = sram_pkg::ADDRESS_WIDTH,
    parameter int DATA_WIDTH     = sram_pkg::DATA_WIDTH,
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic                     clock,
    input  logic                     reset,

    input  logic                     req0_valid,
    input  logic                     req0_write,
    input  logic [ADDRESS_WIDTH-1:0] req0_address,
    input  logic [DATA_WIDTH-1:0]    req0_data,
    output logic                     req0_ready,
    output logic                     rsp0_valid,
    output logic [DATA_WIDTH-1:0]    rsp0_data,

    input  logic                     req1_valid,
    input  logic                     req1_write,
    input  logic [ADDRESS_WIDTH-1:0] req1_address,
    input  logic [DATA_WIDTH-1:0]    req1_data,
    output logic                     req1_ready,
    output logic                     rsp1_valid,
    output logic [DATA_WIDTH-1:0]    rsp1_data,

    output logic                     sram_enable,
    output logic                     sram_readWrite,
    output logic [ADDRESS_WIDTH-1:0] sram_address,
    output logic [DATA_WIDTH-1:0]    sram_dataIn,
    input  logic [DATA_WIDTH-1:0]    sram_dataOut
);

    import sram_pkg::*;

    // Grant signals
    logic                     ready0_s;
    logic                     ready1_s;
    logic                     accept_s;
    port_id_t                 grant_port_s;

    // Fields of the granted request
    logic                     grant_write_s;
    logic [ADDRESS_WIDTH-1:0] grant_address_s;
    logic [DATA_WIDTH-1:0]    grant_data_s;

    // Issue stage: SRAM command registers plus tag
    logic                     sram_enable_r;
    logic                     sram_read_write_r;
    logic [ADDRESS_WIDTH-1:0] sram_address_r;
    logic [DATA_WIDTH-1:0]    sram_data_in_r;
    sram_tag_t                issue_tag_r;

    // Response stage
    logic                     rsp_valid_r;
    sram_tag_t                rsp_tag_r;
    logic [DATA_WIDTH-1:0]    rsp_payload_s;

    rr_arbiter2 #(
        .FIXED_PRIORITY (FIXED_PRIORITY)
    ) u_arb (
        .clock      (clock),
        .reset      (reset),
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .ready0     (ready0_s),
        .ready1     (ready1_s),
        .accept     (accept_s),
        .grant_port (grant_port_s)
    );

    assign req0_ready = ready0_s;
    assign req1_ready = ready1_s;

    // Select the fields of whichever port holds the grant.
    always_comb begin
        grant_write_s   = req0_write;
        grant_address_s = req0_address;
        grant_data_s    = req0_data;
        case (grant_port_s)
            PORT_FETCH: begin
                grant_write_s   = req0_write;
                grant_address_s = req0_address;
                grant_data_s    = req0_data;
            end
            PORT_LSU: begin
                grant_write_s   = req1_write;
                grant_address_s = req1_address;
                grant_data_s    = req1_data;
            end
            default: begin
                grant_write_s   = req0_write;
                grant_address_s = req0_address;
                grant_data_s    = req0_data;
            end
        endcase
    end

    // Issue stage: load the SRAM command on acceptance, otherwise idle the SRAM
    // while keeping address and data where they were.
    always_ff @(posedge clock) begin
        if (reset) begin
            sram_enable_r     <= 1'b0;
            sram_read_write_r <= SRAM_READ;
            sram_address_r    <= '0;
            sram_data_in_r    <= '0;
            issue_tag_r       <= '0;
        end else if (accept_s) begin
            sram_enable_r     <= 1'b1;
            sram_read_write_r <= sram_op(grant_write_s);
            sram_address_r    <= grant_address_s;
            sram_data_in_r    <= grant_data_s;
            issue_tag_r       <= '{port: grant_port_s, write: grant_write_s};
        end else begin
            sram_enable_r     <= 1'b0;
            sram_read_write_r <= sram_read_write_r;
            sram_address_r    <= sram_address_r;
            sram_data_in_r    <= sram_data_in_r;
            issue_tag_r       <= issue_tag_r;
        end
    end

    assign sram_enable    = sram_enable_r;
    assign sram_readWrite = sram_read_write_r;
    assign sram_address   = sram_address_r;
    assign sram_dataIn    = sram_data_in_r;

    // Response stage: follow the issued command by one edge, alongside the SRAM.
    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_valid_r <= 1'b0;
            rsp_tag_r   <= '0;
        end else begin
            rsp_valid_r <= sram_enable_r;
            rsp_tag_r   <= issue_tag_r;
        end
    end

    // Reads return the SRAM output word; write acknowledges carry zero.
    always_comb begin
        rsp_payload_s = '0;
        if (rsp_tag_r.write) begin
            rsp_payload_s = '0;
        end else begin
            rsp_payload_s = sram_dataOut;
        end
    end

    // Steer the response strobe and payload to the tagged port only.
    always_comb begin
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        rsp0_data  = '0;
        rsp1_data  = '0;
        if (rsp_valid_r && !reset) begin
            case (rsp_tag_r.port)
                PORT_FETCH: begin
                    rsp0_valid = 1'b1;
                    rsp0_data  = rsp_payload_s;
                end
                PORT_LSU: begin
                    rsp1_valid = 1'b1;
                    rsp1_data  = rsp_payload_s;
                end
                default: begin
                    rsp0_valid = 1'b0;
                    rsp1_valid = 1'b0;
                end
            endcase
        end else begin
            rsp0_valid = 1'b0;
            rsp1_valid = 1'b0;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter. Two instances share the same request
// stimulus: dut_rr (round-robin) and dut_fx (fixed priority), each with its
// own behavioural SRAM (one-cycle synchronous read).
module tb_sram_arbiter;

    logic        clock = 1'b0;
    logic        reset;

    logic        req0_valid, req0_write, req1_valid, req1_write;
    logic [14:0] req0_address, req1_address;
    logic [31:0] req0_data, req1_data;

    logic        a_req0_ready, a_req1_ready, a_rsp0_valid, a_rsp1_valid;
    logic [31:0] a_rsp0_data, a_rsp1_data;
    logic        a_sram_enable, a_sram_readWrite;
    logic [14:0] a_sram_address;
    logic [31:0] a_sram_dataIn, dout_a;

    logic        b_req0_ready, b_req1_ready, b_rsp0_valid, b_rsp1_valid;
    logic [31:0] b_rsp0_data, b_rsp1_data;
    logic        b_sram_enable, b_sram_readWrite;
    logic [14:0] b_sram_address;
    logic [31:0] b_sram_dataIn, dout_b;

    logic [31:0] mem_a [0:32767];
    logic [31:0] mem_b [0:32767];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    sram_arbiter #(.FIXED_PRIORITY(1'b0)) dut_rr (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_address(req0_address),
        .req0_data(req0_data), .req0_ready(a_req0_ready), .rsp0_valid(a_rsp0_valid),
        .rsp0_data(a_rsp0_data),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_address(req1_address),
        .req1_data(req1_data), .req1_ready(a_req1_ready), .rsp1_valid(a_rsp1_valid),
        .rsp1_data(a_rsp1_data),
        .sram_enable(a_sram_enable), .sram_readWrite(a_sram_readWrite),
        .sram_address(a_sram_address), .sram_dataIn(a_sram_dataIn), .sram_dataOut(dout_a)
    );

    sram_arbiter #(.FIXED_PRIORITY(1'b1)) dut_fx (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_address(req0_address),
        .req0_data(req0_data), .req0_ready(b_req0_ready), .rsp0_valid(b_rsp0_valid),
        .rsp0_data(b_rsp0_data),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_address(req1_address),
        .req1_data(req1_data), .req1_ready(b_req1_ready), .rsp1_valid(b_rsp1_valid),
        .rsp1_data(b_rsp1_data),
        .sram_enable(b_sram_enable), .sram_readWrite(b_sram_readWrite),
        .sram_address(b_sram_address), .sram_dataIn(b_sram_dataIn), .sram_dataOut(dout_b)
    );

    // SRAM model for the round-robin instance
    always @(posedge clock) begin
        if (a_sram_enable) begin
            if (a_sram_readWrite) dout_a <= mem_a[a_sram_address];
            else                  mem_a[a_sram_address] <= a_sram_dataIn;
        end
    end

    // SRAM model for the fixed-priority instance
    always @(posedge clock) begin
        if (b_sram_enable) begin
            if (b_sram_readWrite) dout_b <= mem_b[b_sram_address];
            else                  mem_b[b_sram_address] <= b_sram_dataIn;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive0(input logic v, input logic w, input logic [14:0] a, input logic [31:0] d);
        req0_valid = v; req0_write = w; req0_address = a; req0_data = d;
    endtask

    task automatic drive1(input logic v, input logic w, input logic [14:0] a, input logic [31:0] d);
        req1_valid = v; req1_write = w; req1_address = a; req1_data = d;
    endtask

    initial begin
        logic [31:0] exp_a;
        logic [31:0] exp_b;

        reset = 1'b1;
        drive0(1'b0, 1'b0, 15'h0000, 32'h0);
        drive1(1'b0, 1'b0, 15'h0000, 32'h0);
        @(negedge clock);
        @(negedge clock);
        // Requests presented during reset must not be granted
        drive0(1'b1, 1'b1, 15'h0005, 32'h0000_0001);
        drive1(1'b1, 1'b0, 15'h0006, 32'h0);
        #1;
        check("rst_ready0_a", 32'(a_req0_ready), 32'd0);
        check("rst_ready1_a", 32'(a_req1_ready), 32'd0);
        check("rst_ready0_b", 32'(b_req0_ready), 32'd0);
        check("rst_enable",   32'(a_sram_enable), 32'd0);
        check("rst_rw",       32'(a_sram_readWrite), 32'd1);
        check("rst_addr",     32'(a_sram_address), 32'd0);
        check("rst_din",      a_sram_dataIn, 32'd0);
        check("rst_rsp0_v",   32'(a_rsp0_valid), 32'd0);
        check("rst_rsp1_v",   32'(a_rsp1_valid), 32'd0);
        check("rst_rsp0_d",   a_rsp0_data, 32'd0);

        @(negedge clock);
        reset = 1'b0;
        drive0(1'b0, 1'b0, 15'h0000, 32'h0);
        drive1(1'b0, 1'b0, 15'h0000, 32'h0);

        // Scenario 1: port 0 writes 0xDEADBEEF to 0x0010
        @(negedge clock);
        drive0(1'b1, 1'b1, 15'h0010, 32'hDEAD_BEEF);
        #1;
        check("s1_ready0_a", 32'(a_req0_ready), 32'd1);
        check("s1_ready1_a", 32'(a_req1_ready), 32'd0);
        check("s1_ready0_b", 32'(b_req0_ready), 32'd1);

        // Scenario 2: read the same address right behind the write
        @(negedge clock);
        drive0(1'b1, 1'b0, 15'h0010, 32'h0);
        #1;
        check("s1_enable", 32'(a_sram_enable), 32'd1);
        check("s1_rw",     32'(a_sram_readWrite), 32'd0);
        check("s1_addr",   32'(a_sram_address), 32'h0010);
        check("s1_din",    a_sram_dataIn, 32'hDEAD_BEEF);
        check("s2_ready0", 32'(a_req0_ready), 32'd1);
        check("s1_early_rsp", 32'(a_rsp0_valid), 32'd0);

        @(negedge clock);
        drive0(1'b0, 1'b0, 15'h0000, 32'h0);
        #1;
        check("s1_rsp0_v",  32'(a_rsp0_valid), 32'd1);
        check("s1_rsp0_d",  a_rsp0_data, 32'd0);
        check("s1_rsp1_v",  32'(a_rsp1_valid), 32'd0);
        check("s2_enable",  32'(a_sram_enable), 32'd1);
        check("s2_rw",      32'(a_sram_readWrite), 32'd1);

        @(negedge clock);
        #1;
        check("s2_rsp0_v",   32'(a_rsp0_valid), 32'd1);
        check("s2_rsp0_d",   a_rsp0_data, 32'hDEAD_BEEF);
        check("s2_rsp1_v",   32'(a_rsp1_valid), 32'd0);
        check("s2_rsp0_d_b", b_rsp0_data, 32'hDEAD_BEEF);
        check("s2_idle_en",  32'(a_sram_enable), 32'd0);

        // Preload 0x0001 via port 0 and 0x0002 via port 1 (leaves pointer on port 0)
        @(negedge clock);
        drive0(1'b1, 1'b1, 15'h0001, 32'hA0A0_0001);
        #1;
        check("pre_ready0", 32'(a_req0_ready), 32'd1);
        check("pre_rsp_gone", 32'(a_rsp0_valid), 32'd0);

        @(negedge clock);
        drive0(1'b0, 1'b0, 15'h0000, 32'h0);
        drive1(1'b1, 1'b1, 15'h0002, 32'hB1B1_0002);
        #1;
        check("pre_ready1_a", 32'(a_req1_ready), 32'd1);
        check("pre_ready1_b", 32'(b_req1_ready), 32'd1);

        // Scenarios 3/4: both ports hold reads for four cycles
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            drive0(1'b1, 1'b0, 15'h0001, 32'h0);
            drive1(1'b1, 1'b0, 15'h0002, 32'h0);
            #1;
            check($sformatf("s3_ready0_a[%0d]", i), 32'(a_req0_ready), 32'((i % 2) == 0));
            check($sformatf("s3_ready1_a[%0d]", i), 32'(a_req1_ready), 32'((i % 2) == 1));
            check($sformatf("s4_ready0_b[%0d]", i), 32'(b_req0_ready), 32'd1);
            check($sformatf("s4_ready1_b[%0d]", i), 32'(b_req1_ready), 32'd0);
            check($sformatf("s3_enable_a[%0d]", i), 32'(a_sram_enable), 32'd1);
            check($sformatf("s4_enable_b[%0d]", i), 32'(b_sram_enable), 32'd1);
            // Round-robin: write acks (i=0,1) then reads alternate ports
            if (i < 2) exp_a = 32'h0;
            else if ((i % 2) == 1) exp_a = 32'hB1B1_0002;
            else exp_a = 32'hA0A0_0001;
            check($sformatf("s3_rsp0_v_a[%0d]", i), 32'(a_rsp0_valid), 32'((i % 2) == 0));
            check($sformatf("s3_rsp1_v_a[%0d]", i), 32'(a_rsp1_valid), 32'((i % 2) == 1));
            if ((i % 2) == 1) check($sformatf("s3_rsp1_d_a[%0d]", i), a_rsp1_data, exp_a);
            else              check($sformatf("s3_rsp0_d_a[%0d]", i), a_rsp0_data, exp_a);
            // Fixed priority: port-1 write ack at i=1, otherwise port-0 traffic
            if (i < 2) exp_b = 32'h0;
            else exp_b = 32'hA0A0_0001;
            check($sformatf("s4_rsp0_v_b[%0d]", i), 32'(b_rsp0_valid), 32'(i != 1));
            check($sformatf("s4_rsp1_v_b[%0d]", i), 32'(b_rsp1_valid), 32'(i == 1));
            if (i == 1) check($sformatf("s4_rsp1_d_b[%0d]", i), b_rsp1_data, exp_b);
            else        check($sformatf("s4_rsp0_d_b[%0d]", i), b_rsp0_data, exp_b);
        end

        // Port 0 drops: port 1 is served on both instances
        @(negedge clock);
        drive0(1'b0, 1'b0, 15'h0000, 32'h0);
        #1;
        check("s4_ready1_b_late", 32'(b_req1_ready), 32'd1);
        check("s3_ready1_a_late", 32'(a_req1_ready), 32'd1);
        check("s3_ready0_a_late", 32'(a_req0_ready), 32'd0);
        check("s3_rsp0_d_a_c13",  a_rsp0_data, 32'hA0A0_0001);
        check("s4_rsp0_d_b_c13",  b_rsp0_data, 32'hA0A0_0001);

        @(negedge clock);
        drive1(1'b0, 1'b0, 15'h0000, 32'h0);
        #1;
        check("s3_rsp1_v_a_c14", 32'(a_rsp1_valid), 32'd1);
        check("s3_rsp1_d_a_c14", a_rsp1_data, 32'hB1B1_0002);
        check("s4_rsp0_d_b_c14", b_rsp0_data, 32'hA0A0_0001);

        @(negedge clock);
        #1;
        check("s3_rsp1_d_a_c15", a_rsp1_data, 32'hB1B1_0002);
        check("s4_rsp1_v_b_c15", 32'(b_rsp1_valid), 32'd1);
        check("s4_rsp1_d_b_c15", b_rsp1_data, 32'hB1B1_0002);
        check("s3_idle_en",      32'(a_sram_enable), 32'd0);

        // Scenario 5: port 1 read accepted, then one reset cycle
        @(negedge clock);
        drive1(1'b1, 1'b0, 15'h0002, 32'h0);
        #1;
        check("s5_ready1", 32'(a_req1_ready), 32'd1);

        @(negedge clock);
        reset = 1'b1;
        drive1(1'b0, 1'b0, 15'h0000, 32'h0);
        drive0(1'b1, 1'b1, 15'h0003, 32'hFFFF_FFFF);
        #1;
        check("s5_rst_ready0_a", 32'(a_req0_ready), 32'd0);
        check("s5_rst_ready0_b", 32'(b_req0_ready), 32'd0);
        check("s5_rst_ready1_a", 32'(a_req1_ready), 32'd0);
        check("s5_issue_en",     32'(a_sram_enable), 32'd1);

        @(negedge clock);
        reset = 1'b0;
        drive0(1'b0, 1'b0, 15'h0000, 32'h0);
        #1;
        check("s5_en_a",    32'(a_sram_enable), 32'd0);
        check("s5_en_b",    32'(b_sram_enable), 32'd0);
        check("s5_rsp1_a",  32'(a_rsp1_valid), 32'd0);
        check("s5_rsp1_b",  32'(b_rsp1_valid), 32'd0);
        check("s5_addr",    32'(a_sram_address), 32'd0);

        @(negedge clock);
        #1;
        check("s5_rsp1_a_late", 32'(a_rsp1_valid), 32'd0);
        check("s5_rsp0_a_late", 32'(a_rsp0_valid), 32'd0);
        check("s5_en_late",     32'(a_sram_enable), 32'd0);

        // Scenario 6: write then read the top address, then idle
        @(negedge clock);
        drive0(1'b1, 1'b1, 15'h7FFF, 32'h1234_5678);
        #1;
        check("s6_ready0_w", 32'(a_req0_ready), 32'd1);

        @(negedge clock);
        drive0(1'b1, 1'b0, 15'h7FFF, 32'h0);
        #1;
        check("s6_ready0_r", 32'(a_req0_ready), 32'd1);
        check("s6_en_w",     32'(a_sram_enable), 32'd1);
        check("s6_rw_w",     32'(a_sram_readWrite), 32'd0);
        check("s6_addr_w",   32'(a_sram_address), 32'h7FFF);
        check("s6_din_w",    a_sram_dataIn, 32'h1234_5678);

        @(negedge clock);
        drive0(1'b0, 1'b0, 15'h0000, 32'h0);
        #1;
        check("s6_ack_v",  32'(a_rsp0_valid), 32'd1);
        check("s6_ack_d",  a_rsp0_data, 32'd0);
        check("s6_en_r",   32'(a_sram_enable), 32'd1);
        check("s6_rw_r",   32'(a_sram_readWrite), 32'd1);
        check("s6_addr_r", 32'(a_sram_address), 32'h7FFF);

        @(negedge clock);
        #1;
        check("s6_rd_v",    32'(a_rsp0_valid), 32'd1);
        check("s6_rd_d",    a_rsp0_data, 32'h1234_5678);
        check("s6_rd_d_b",  b_rsp0_data, 32'h1234_5678);
        check("s6_en_idle", 32'(a_sram_enable), 32'd0);
        check("s6_addr_hold", 32'(a_sram_address), 32'h7FFF);

        @(negedge clock);
        #1;
        check("s6_rsp_end_v", 32'(a_rsp0_valid), 32'd0);
        check("s6_rsp_end_d", a_rsp0_data, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the 32K x 32 single-port SRAM (15-bit address, 32-bit data, one-cycle synchronous read).
- Port 0 is instruction fetch; port 1 is load/store.
- Grants at most one access per cycle, drives registered SRAM command signals, and returns read data tagged to the originating port.
- Sits between the CPU front-end/LSU and the SRAM; it is the only master of the SRAM.

Parameters:
ADDRESS_WIDTH, 15, SRAM word-address width
DATA_WIDTH, 32, SRAM word width
FIXED_PRIORITY, 0, 0 = round-robin between ports; 1 = port 0 always wins

Ports:
clock  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
req0_valid  input  1  port 0 request present
req0_write  input  1  port 0: 1 = write, 0 = read
req0_address  input  ADDRESS_WIDTH  port 0 word address
req0_data  input  DATA_WIDTH  port 0 write data
req0_ready  output  1  port 0 grant; transfer occurs when valid & ready at posedge
rsp0_valid  output  1  port 0 response strobe, one cycle
rsp0_data  output  DATA_WIDTH  port 0 read data, valid with rsp0_valid
req1_valid, req1_write, req1_address, req1_data, req1_ready, rsp1_valid, rsp1_data  as port 0, for port 1
sram_enable  output  1  to SRAM enable
sram_readWrite  output  1  to SRAM readWrite (1 = read, 0 = write)
sram_address  output  ADDRESS_WIDTH  to SRAM address
sram_dataIn  output  DATA_WIDTH  to SRAM dataIn
sram_dataOut  input  DATA_WIDTH  from SRAM dataOut

Behaviour:
- Reset values:
  - all reqN_ready = 0 and all rspN_valid = 0 during reset.
  - rspN_data = 0.
  - sram_enable = 0, sram_readWrite = 1, sram_address = 0, sram_dataIn = 0.
  - Round-robin pointer = port 0 preferred.
- Grant is combinational from reqN_valid and the pointer:
  - Only one port is valid: that port gets ready.
  - Both ports valid: the preferred port gets ready.
  - readyN is never asserted without validN, and never both in the same cycle.
- Pointer update: on an accepted transfer with FIXED_PRIORITY = 0, the preferred port becomes the other port. With FIXED_PRIORITY = 1, port 0 is always preferred.
- Issue stage (registered): at the posedge of acceptance (edge N), the SRAM command registers load:
  - sram_enable = 1
  - sram_readWrite = ~write
  - sram_address and sram_dataIn from the granted request
  - the granted port id and op, held in a tag register
- With no acceptance at edge N, sram_enable = 0 for the following cycle; address and data hold their previous values.
- SRAM executes the command at edge N+1.
- Response stage:
  - Response register loads at edge N+1; rspP_valid = 1 during cycle N+2 for exactly one cycle, on the tagged port only.
  - Read: rspP_data = sram_dataOut. Write: rspP_data = 0; the write acknowledge uses the same timing.
  - Latency from acceptance to response is 2 cycles. Throughput is 1 access per cycle; back-to-back grants are allowed, including alternating ports.
- Responses have no back-pressure: requesters must consume rsp in the cycle it is valid.
- Request fields must be held stable while valid & !ready; they are sampled only at acceptance.
- Read of a just-written address: a read accepted in the cycle after a write to the same address returns the new data, because the SRAM write completes one edge before the read.
- Reset mid-operation:
  - In-flight issue and response stages are discarded; no rsp is emitted for them.
  - sram_enable = 0 from the first reset edge.
  - A write already presented to the SRAM at that edge completes; later writes are not issued.
- No internal state machine beyond the two-stage pipeline valid bits, the tag, and the priority pointer. An idle pipeline holds sram_enable = 0 to save power.

Decomposition:
- Package sram_pkg:
  - ADDRESS_WIDTH and DATA_WIDTH constants
  - port-id type (1 bit)
  - SRAM_READ = 1 / SRAM_WRITE = 0 encodings
  - request struct (write, address, data)
- One sub-module, rr_arbiter2: combinational two-way grant plus the registered priority pointer, with FIXED_PRIORITY passed through.

Test Plan:
1. Reset, then port 0 writes 0xDEADBEEF to 0x0010 at cycle 3 -> req0_ready = 1 at cycle 3; sram_enable = 1, readWrite = 0, address = 0x0010 at cycle 4; rsp0_valid at cycle 5 with data 0.
2. Port 0 reads 0x0010 immediately after the write in scenario 1 -> rsp0_valid two cycles after acceptance with rsp0_data = 0xDEADBEEF; rsp1_valid stays 0.
3. Both ports hold valid reads (0x0001, 0x0002) for 4 cycles, round-robin -> grants alternate 0,1,0,1; responses alternate ports with the correct data; sram_enable is continuously 1.
4. Same stimulus as scenario 3 with FIXED_PRIORITY = 1 -> port 0 granted all 4 cycles; req1_ready stays 0 until req0_valid drops.
5. Port 1 read accepted, then reset asserted for 1 cycle on the next edge -> no rsp1_valid; sram_enable = 0 after the reset edge; all ready = 0 during reset.
6. Write 0x7FFF = 0x12345678, then read 0x7FFF, then idle -> correct data at the top address; sram_enable returns to 0 one cycle after the last acceptance.
